// File: rtl/score_bcd_digitizer.sv
// score_bcd_digitizer: sequential double-dabble binary to BCD digits with leading-zero blanking
module score_bcd_digitizer #(
  parameter int BIN_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        value,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    overflow
);
  localparam int SW = 4*NUM_DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  localparam logic [31:0] MAX = 32'(10**NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state;
  logic [BIN_W-1:0] shift;
  logic [SW-1:0] scratch, adj;
  logic [CW-1:0] cnt;
  logic ovf_pending, hi_zero;
  logic [NUM_DIGITS-1:0] lz;
  assign busy = state != IDLE;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  // a digit is blank only if it and every digit above it are zero; the units digit always shows
  always_comb begin
    lz = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      hi_zero = hi_zero && scratch[4*i+:4] == 4'd0;
      lz[i] = hi_zero;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      overflow <= 1'b0;
      digits <= '0;
      blank <= BLANK_RST;
      shift <= '0;
      scratch <= '0;
      cnt <= '0;
      ovf_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shift <= value;
          scratch <= '0;
          cnt <= CW'(BIN_W);
          ovf_pending <= 32'(value) > MAX;
          state <= SHIFT;
        end
        SHIFT: begin
          scratch <= {adj[SW-2:0], shift[BIN_W-1]};
          shift <= shift << 1;
          cnt <= cnt - CW'(1);
          state <= cnt == CW'(1) ? FINISH : SHIFT;
        end
        FINISH: begin
          done <= 1'b1;
          overflow <= ovf_pending;
          digits <= ovf_pending ? {NUM_DIGITS{4'd9}} : scratch;
          blank <= ovf_pending ? '0 : lz;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_digitizer.sv
// tb_score_bcd_digitizer: directed checks of conversion, latency, saturation, ignore, back-to-back and abort
module tb_score_bcd_digitizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [13:0] value = '0;
  logic busy, done, overflow;
  logic [15:0] digits;
  logic [3:0] blank;
  int tests = 0;
  int fails = 0;
  int n;

  score_bcd_digitizer #(.BIN_W(14), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .digits(digits), .blank(blank), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [13:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL reset_digits got %h exp 0000", digits); end
    tests++; if (blank !== 4'b1110) begin fails++; $display("FAIL reset_blank got %b exp 1110", blank); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_1234;
    do_start(14'd1234);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_1234 got %b exp 1", busy); end
    wait_done(n);
    tests++; if (n !== 15) begin fails++; $display("FAIL latency_1234 got %0d exp 15", n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_in_done got %b exp 0", busy); end
    tests++; if (digits !== 16'h1234) begin fails++; $display("FAIL digits_1234 got %h exp 1234", digits); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL blank_1234 got %b exp 0000", blank); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_1234 got %b exp 0", overflow); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width got %b exp 0", done); end
    tests++; if (digits !== 16'h1234) begin fails++; $display("FAIL hold_1234 got %h exp 1234", digits); end
  endtask

  task automatic test_small;
    do_start(14'd42);
    wait_done(n);
    tests++; if (digits !== 16'h0042) begin fails++; $display("FAIL digits_42 got %h exp 0042", digits); end
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL blank_42 got %b exp 1100", blank); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_42 got %b exp 0", overflow); end
    do_start(14'd0);
    repeat (3) @(negedge clk);
    tests++; if (digits !== 16'h0042 || blank !== 4'b1100) begin fails++; $display("FAIL hold_during_conv got %h/%b exp 0042/1100", digits, blank); end
    wait_done(n);
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL digits_0 got %h exp 0000", digits); end
    tests++; if (blank !== 4'b1110) begin fails++; $display("FAIL blank_0 got %b exp 1110", blank); end
  endtask

  task automatic test_saturation;
    do_start(14'd9999);
    wait_done(n);
    tests++; if (digits !== 16'h9999) begin fails++; $display("FAIL digits_9999 got %h exp 9999", digits); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_9999 got %b exp 0", overflow); end
    do_start(14'd16383);
    wait_done(n);
    tests++; if (digits !== 16'h9999) begin fails++; $display("FAIL digits_16383 got %h exp 9999", digits); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_16383 got %b exp 1", overflow); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL blank_16383 got %b exp 0000", blank); end
    do_start(14'd10000);
    wait_done(n);
    tests++; if (overflow !== 1'b1 || digits !== 16'h9999) begin fails++; $display("FAIL ovf_10000 got %b/%h exp 1/9999", overflow, digits); end
  endtask

  task automatic test_ignore_busy;
    int dones;
    do_start(14'd7);
    repeat (4) @(negedge clk);
    start = 1'b1;
    value = 14'd8000;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    tests++; if (n !== 10) begin fails++; $display("FAIL latency_7 got %0d exp 10", n); end
    tests++; if (digits !== 16'h0007) begin fails++; $display("FAIL digits_7 got %h exp 0007", digits); end
    tests++; if (blank !== 4'b1110) begin fails++; $display("FAIL blank_7 got %b exp 1110", blank); end
    dones = 0;
    repeat (20) begin @(negedge clk); if (done) dones++; end
    tests++; if (dones !== 0) begin fails++; $display("FAIL extra_done got %0d exp 0", dones); end
  endtask

  task automatic test_back_to_back;
    do_start(14'd8000);
    wait_done(n);
    tests++; if (digits !== 16'h8000) begin fails++; $display("FAIL digits_8000 got %h exp 8000", digits); end
    start = 1'b1;
    value = 14'd321;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got %b exp 1", busy); end
    wait_done(n);
    tests++; if (n !== 15) begin fails++; $display("FAIL latency_b2b got %0d exp 15", n); end
    tests++; if (digits !== 16'h0321) begin fails++; $display("FAIL digits_321 got %h exp 0321", digits); end
    tests++; if (blank !== 4'b1000) begin fails++; $display("FAIL blank_321 got %b exp 1000", blank); end
  endtask

  task automatic test_abort;
    int dones;
    do_start(14'd500);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin @(negedge clk); if (done) dones++; end
    tests++; if (dones !== 0) begin fails++; $display("FAIL abort_done got %0d exp 0", dones); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL abort_digits got %h exp 0000", digits); end
    tests++; if (blank !== 4'b1110) begin fails++; $display("FAIL abort_blank got %b exp 1110", blank); end
    do_start(14'd500);
    wait_done(n);
    tests++; if (n !== 15) begin fails++; $display("FAIL latency_500 got %0d exp 15", n); end
    tests++; if (digits !== 16'h0500) begin fails++; $display("FAIL digits_500 got %h exp 0500", digits); end
    tests++; if (blank !== 4'b1000) begin fails++; $display("FAIL blank_500 got %b exp 1000", blank); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_500 got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_1234;
    test_small;
    test_saturation;
    test_ignore_busy;
    test_back_to_back;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
